// File: rtl/dma_mem_responder_if.sv
`default_nettype none
// dma_mem_responder_if -- per-core request/grant/valid bus, downstream memory port and status (rev 1.0)
interface dma_mem_responder_if #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 48,
   parameter int DATA_W    = 64
);
   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES-1:0]        core_we;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES*DATA_W-1:0] core_wdata;
   logic [NUM_CORES-1:0]        core_gnt;
   logic [NUM_CORES-1:0]        core_valid;
   logic [DATA_W-1:0]           core_rdata;
   logic                        mem_req;
   logic                        mem_we;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic                        mem_ack;
   logic                        mem_rvalid;
   logic [DATA_W-1:0]           mem_rdata;
   logic                        busy;
   logic                        err_misaligned;
   logic [31:0]                 rd_count;
   logic [31:0]                 wr_count;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata, mem_ack, mem_rvalid, mem_rdata,
      output core_gnt, core_valid, core_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             busy, err_misaligned, rd_count, wr_count
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata, mem_ack, mem_rvalid, mem_rdata,
      input  core_gnt, core_valid, core_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             busy, err_misaligned, rd_count, wr_count
   );
endinterface
`default_nettype wire

// File: rtl/dma_mem_responder.sv
`default_nettype none
// dma_mem_responder -- round-robin arbiter forwarding one core access at a time to a
// variable-latency memory port and returning read data with a valid pulse (rev 1.0)
module dma_mem_responder #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 48,
   parameter int DATA_W    = 64
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   dma_mem_responder_if.slave bus
);
   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_MEM    = 2'd2,
      S_RDWAIT = 2'd3
   } state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_last;
   logic [IDX_W-1:0]     r_sel;
   logic [NUM_CORES-1:0] r_gnt;
   logic [NUM_CORES-1:0] r_valid;
   logic [DATA_W-1:0]    r_rdata;
   logic                 r_mem_req;
   logic                 r_mem_we;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [DATA_W-1:0]    r_mem_wdata;
   logic                 r_err;
   logic [31:0]          r_rd_count;
   logic [31:0]          r_wr_count;

   logic [IDX_W-1:0]     w_idx;
   logic [IDX_W-1:0]     w_winner;
   logic                 w_any;
   logic                 w_we;
   logic [ADDR_W-1:0]    w_addr;
   logic [DATA_W-1:0]    w_wdata;

   // Walk the ring from farthest to nearest so the closest requester after r_last wins.
   always_comb begin
      w_idx    = r_last;
      w_winner = r_last;
      w_any    = 1'b0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         w_idx = IDX_W'((int'(r_last) + k) % NUM_CORES);
         if (bus.core_req[w_idx]) begin
            w_winner = w_idx;
            w_any    = 1'b1;
         end
      end
   end

   assign w_we    = bus.core_we[r_sel];
   assign w_addr  = bus.core_addr[int'(r_sel)*ADDR_W +: ADDR_W];
   assign w_wdata = bus.core_wdata[int'(r_sel)*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_last      <= IDX_W'(NUM_CORES - 1);
         r_sel       <= '0;
         r_gnt       <= '0;
         r_valid     <= '0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_err       <= 1'b0;
         r_rd_count  <= '0;
         r_wr_count  <= '0;
      end else begin
         r_gnt   <= '0;
         r_valid <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_GRANT;
                  r_last  <= w_winner;
                  r_sel   <= w_winner;
                  r_gnt   <= NUM_CORES'(1) << w_winner;
               end
            end
            S_GRANT: begin
               r_mem_req   <= 1'b1;
               r_mem_we    <= w_we;
               r_mem_addr  <= {w_addr[ADDR_W-1:3], 3'b000};
               r_mem_wdata <= w_wdata;
               if (w_addr[2:0] != 3'b000) begin
                  r_err <= 1'b1;
               end
               if (w_we) begin
                  r_wr_count <= r_wr_count + 32'd1;
               end else begin
                  r_rd_count <= r_rd_count + 32'd1;
               end
               r_state <= S_MEM;
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= r_mem_we ? S_IDLE : S_RDWAIT;
               end
            end
            S_RDWAIT: begin
               if (bus.mem_rvalid) begin
                  r_rdata <= bus.mem_rdata;
                  r_valid <= NUM_CORES'(1) << r_sel;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.core_gnt       = r_gnt;
   assign bus.core_valid     = r_valid;
   assign bus.core_rdata     = r_rdata;
   assign bus.mem_req        = r_mem_req;
   assign bus.mem_we         = r_mem_we;
   assign bus.mem_addr       = r_mem_addr;
   assign bus.mem_wdata      = r_mem_wdata;
   assign bus.busy           = (r_state != S_IDLE);
   assign bus.err_misaligned = r_err;
   assign bus.rd_count       = r_rd_count;
   assign bus.wr_count       = r_wr_count;
endmodule
`default_nettype wire

// File: tb/tb_dma_mem_responder.sv
`default_nettype none
// tb_dma_mem_responder -- randomized cores and memory against a transaction-level model (rev 1.0)
module tb_dma_mem_responder;
   localparam int NC = 4;
   localparam int AW = 48;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dma_mem_responder_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

   dma_mem_responder #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference model (one transaction in flight) ----------------
   typedef struct {
      logic [NC-1:0] gnt;
      logic [NC-1:0] valid;
      logic [DW-1:0] rdata;
      logic          mem_req;
      logic          mem_we;
      logic [AW-1:0] mem_addr;
      logic [DW-1:0] mem_wdata;
      logic          busy;
      logic          err;
      logic [31:0]   rd;
      logic [31:0]   wr;
      int            last;
      int            who;
      bit            rd_wait;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.gnt = '0; r.valid = '0; r.rdata = '0; r.mem_req = 1'b0; r.mem_we = 1'b0;
      r.mem_addr = '0; r.mem_wdata = '0; r.busy = 1'b0; r.err = 1'b0;
      r.rd = '0; r.wr = '0; r.last = NC - 1; r.who = 0; r.rd_wait = 1'b0;
      return r;
   endfunction

   function automatic model_t model_step(model_t s);
      model_t        n;
      logic [AW-1:0] a;
      bit            found;
      n = s;
      n.gnt = '0;
      n.valid = '0;
      found = 1'b0;
      if (!s.busy) begin
         for (int k = 1; k <= NC; k++) begin
            if (!found && bus.core_req[(s.last + k) % NC]) begin
               found = 1'b1;
               n.who = (s.last + k) % NC;
            end
         end
         if (found) begin
            n.last = n.who;
            n.busy = 1'b1;
            n.gnt[n.who] = 1'b1;
         end
      end else if (s.gnt != '0) begin
         a = bus.core_addr[s.who*AW +: AW];
         n.mem_req   = 1'b1;
         n.mem_we    = bus.core_we[s.who];
         n.mem_addr  = a & ~48'h7;
         n.mem_wdata = bus.core_wdata[s.who*DW +: DW];
         if (a[2:0] != 3'b000) n.err = 1'b1;
         if (bus.core_we[s.who]) n.wr = s.wr + 1;
         else                    n.rd = s.rd + 1;
      end else if (s.mem_req) begin
         if (bus.mem_ack) begin
            n.mem_req = 1'b0;
            if (s.mem_we) n.busy = 1'b0;
            else          n.rd_wait = 1'b1;
         end
      end else if (s.rd_wait && bus.mem_rvalid) begin
         n.rd_wait = 1'b0;
         n.busy = 1'b0;
         n.rdata = bus.mem_rdata;
         n.valid[s.who] = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m);
   end

   // ---------------- memory responder ----------------
   int  ack_wait = -1;
   int  rv_cnt = 0;
   int  ack_lo = 0, ack_hi = 0, rd_lo = 1, rd_hi = 1, stray_pct = 0;
   bit  force_rd = 1'b0;
   logic [DW-1:0] force_val = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         ack_wait = -1;
         rv_cnt = 0;
         bus.mem_ack = 1'b0;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata = '0;
      end else begin
         bus.mem_ack = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata = force_rd ? force_val : {$urandom, $urandom};
            end
         end else if ($urandom_range(99) < stray_pct) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = {$urandom, $urandom};
         end
         if (bus.mem_req) begin
            if (ack_wait < 0) ack_wait = $urandom_range(ack_hi, ack_lo);
            if (ack_wait == 0) begin
               bus.mem_ack = 1'b1;
               ack_wait = -1;
               if (!bus.mem_we) rv_cnt = $urandom_range(rd_hi, rd_lo);
            end else begin
               ack_wait--;
            end
         end else if ($urandom_range(99) < stray_pct) begin
            bus.mem_ack = 1'b1;
         end
      end
   end

   // ---------------- core drivers and logs ----------------
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   req_t          q [NC][$];
   bit [NC-1:0]   gnt_seen;
   int            gnt_log[$], gnt_cyc[$], valid_log[$], valid_cyc[$];
   logic [AW-1:0] maddr_log[$];
   logic [DW-1:0] mdata_log[$];
   int            mreq_cnt;
   bit            mreq_prev;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(int c, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      q[c].push_back(r);
   endtask

   function automatic req_t rand_req();
      req_t        r;
      logic [63:0] a;
      a = {$urandom, $urandom};
      r.we = 1'($urandom_range(1));
      r.addr = a[AW-1:0];
      if ($urandom_range(7) != 0) r.addr[2:0] = 3'b000;
      r.wdata = {$urandom, $urandom};
      return r;
   endfunction

   task automatic compare();
      if (!rst_n) return;
      chk("gnt", bus.core_gnt, m.gnt);
      chk("valid", bus.core_valid, m.valid);
      chk("rdata", bus.core_rdata, m.rdata);
      chk("mem_req", bus.mem_req, m.mem_req);
      if (m.mem_req) begin
         chk("mem_we", bus.mem_we, m.mem_we);
         chk("mem_addr", bus.mem_addr, m.mem_addr);
         chk("mem_wdata", bus.mem_wdata, m.mem_wdata);
      end
      chk("busy", bus.busy, m.busy);
      chk("err", bus.err_misaligned, m.err);
      chk("rd_count", bus.rd_count, m.rd);
      chk("wr_count", bus.wr_count, m.wr);
   endtask

   task automatic run(int ncyc, bit gen);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         compare();
         for (int i = 0; i < NC; i++) begin
            if (gnt_seen[i]) begin
               void'(q[i].pop_front());
               gnt_seen[i] = 1'b0;
            end
            if (gen && q[i].size() == 0 && $urandom_range(3) == 0) q[i].push_back(rand_req());
            if (q[i].size() != 0) begin
               bus.core_req[i] = 1'b1;
               bus.core_we[i] = q[i][0].we;
               bus.core_addr[i*AW +: AW] = q[i][0].addr;
               bus.core_wdata[i*DW +: DW] = q[i][0].wdata;
            end else begin
               bus.core_req[i] = 1'b0;
            end
            if (bus.core_gnt[i]) begin
               gnt_seen[i] = 1'b1;
               gnt_log.push_back(i);
               gnt_cyc.push_back(cyc);
            end
            if (bus.core_valid[i]) begin
               valid_log.push_back(i);
               valid_cyc.push_back(cyc);
            end
         end
         if (bus.mem_req) begin
            mreq_cnt++;
            if (!mreq_prev) begin
               maddr_log.push_back(bus.mem_addr);
               mdata_log.push_back(bus.mem_wdata);
            end
         end
         mreq_prev = bus.mem_req;
      end
   endtask

   task automatic clear_tb();
      for (int i = 0; i < NC; i++) q[i].delete();
      gnt_seen = '0;
      gnt_log.delete(); gnt_cyc.delete(); valid_log.delete(); valid_cyc.delete();
      maddr_log.delete(); mdata_log.delete();
      mreq_cnt = 0;
      mreq_prev = 1'b0;
      bus.core_req = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_tb();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
      clear_tb();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset gnt", bus.core_gnt, 0);
      chk("reset mem_req", bus.mem_req, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset rd_count", bus.rd_count, 0);
      chk("reset err", bus.err_misaligned, 0);
      rst_n = 1'b1;

      // Single read from core 1, rvalid three edges after ack
      force_rd = 1'b1; force_val = 64'hDEADBEEF_00000001;
      ack_lo = 0; ack_hi = 0; rd_lo = 3; rd_hi = 3; stray_pct = 0;
      push(1, 1'b0, 48'h1000, '0);
      run(20, 1'b0);
      chk("A gnt count", gnt_log.size(), 1);
      chk("A gnt core", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
      chk("A mem_addr", (maddr_log.size() > 0) ? maddr_log[0] : '1, 48'h1000);
      chk("A valid count", valid_log.size(), 1);
      chk("A valid core", (valid_log.size() > 0) ? valid_log[0] : -1, 1);
      chk("A gnt-to-valid cycles",
          (valid_cyc.size() > 0 && gnt_cyc.size() > 0) ? valid_cyc[0] - gnt_cyc[0] : -1, 5);
      chk("A rdata", bus.core_rdata, 64'hDEADBEEF_00000001);
      chk("A rd_count", bus.rd_count, 1);
      force_rd = 1'b0;

      // Back-to-back writes from core 0
      do_reset();
      for (int k = 0; k < 4; k++) push(0, 1'b1, 48'h2000 + 48'(8 * k), 64'(k + 1));
      run(25, 1'b0);
      chk("B gnt count", gnt_log.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) chk("B gnt spacing", (gnt_cyc.size() > k) ? gnt_cyc[k] - gnt_cyc[k-1] : -1, 3);
         chk("B mem_addr", (maddr_log.size() > k) ? maddr_log[k] : '1, 48'h2000 + 48'(8 * k));
         chk("B mem_wdata", (mdata_log.size() > k) ? mdata_log[k] : '1, 64'(k + 1));
      end
      chk("B wr_count", bus.wr_count, 4);

      // Round robin: cores 0, 2, 3 together, core 0 asks again
      do_reset();
      rd_lo = 1; rd_hi = 1;
      push(0, 1'b0, 48'h100, '0); push(0, 1'b0, 48'h108, '0);
      push(2, 1'b0, 48'h200, '0); push(3, 1'b0, 48'h300, '0);
      run(40, 1'b0);
      chk("C gnt count", gnt_log.size(), 4);
      chk("C order 0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
      chk("C order 1", (gnt_log.size() > 1) ? gnt_log[1] : -1, 2);
      chk("C order 2", (gnt_log.size() > 2) ? gnt_log[2] : -1, 3);
      chk("C order 3", (gnt_log.size() > 3) ? gnt_log[3] : -1, 0);

      // Backpressure: ack withheld for 10 cycles
      do_reset();
      ack_lo = 10; ack_hi = 10;
      push(0, 1'b1, 48'h4000, 64'h55); push(2, 1'b1, 48'h4008, 64'h66);
      run(40, 1'b0);
      chk("D gnt count", gnt_log.size(), 2);
      chk("D gnt spacing", (gnt_cyc.size() > 1) ? gnt_cyc[1] - gnt_cyc[0] : -1, 13);
      chk("D mem_req cycles", mreq_cnt, 22);
      chk("D mem_addr", (maddr_log.size() > 0) ? maddr_log[0] : '1, 48'h4000);

      // Misaligned write with stray rvalid/ack activity
      do_reset();
      ack_lo = 1; ack_hi = 1; stray_pct = 100;
      push(2, 1'b1, 48'h3005, 64'hA5); push(2, 1'b1, 48'h3008, 64'hA6);
      run(20, 1'b0);
      chk("E mem_addr aligned", (maddr_log.size() > 0) ? maddr_log[0] : '1, 48'h3000);
      chk("E second mem_addr", (maddr_log.size() > 1) ? maddr_log[1] : '1, 48'h3008);
      chk("E no valid", valid_log.size(), 0);
      chk("E err sticky", bus.err_misaligned, 1);

      // Reset asserted while waiting for read data
      do_reset();
      ack_lo = 0; ack_hi = 0; rd_lo = 8; rd_hi = 8; stray_pct = 0;
      push(1, 1'b0, 48'h5000, '0);
      run(5, 1'b0);
      chk("F busy before reset", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("F async busy", bus.busy, 0);
      chk("F async mem_req", bus.mem_req, 0);
      chk("F async valid", bus.core_valid, 0);
      chk("F async rd_count", bus.rd_count, 0);
      clear_tb();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      force_rd = 1'b1; force_val = 64'h0123_4567_89AB_CDEF;
      rd_lo = 2; rd_hi = 2;
      push(1, 1'b0, 48'h5008, '0);
      run(20, 1'b0);
      chk("F valid count", valid_log.size(), 1);
      chk("F valid core", (valid_log.size() > 0) ? valid_log[0] : -1, 1);
      chk("F rdata", bus.core_rdata, 64'h0123_4567_89AB_CDEF);
      chk("F rd_count", bus.rd_count, 1);
      force_rd = 1'b0;

      // Randomized traffic against the model
      do_reset();
      ack_lo = 0; ack_hi = 3; rd_lo = 1; rd_hi = 4; stray_pct = 10;
      run(3000, 1'b1);
      chk("G traffic seen", (gnt_log.size() > 100) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dma_mem_responder.md
# dma_mem_responder

Responder end of the per-core DMA request/grant/valid interface used by the NTT engine cores. It takes requests from up to NUM_CORES initiators, grants one at a time in round-robin order, and forwards each accepted access to a single downstream memory port with variable latency. It returns read data to the requesting core with a one-cycle valid pulse. It sits between the core array and the host-memory/DRAM model, one instance per cluster.

## Interface
- NUM_CORES, 4: number of initiator ports; range 1..8
- ADDR_W, 48: byte address width
- DATA_W, 64: data word width
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- core_req  in  NUM_CORES  per-core request; held until that core's gnt is sampled
- core_we  in  NUM_CORES  per-core write enable (1 = write, 0 = read)
- core_addr  in  NUM_CORES*ADDR_W  packed byte addresses; core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  packed write data; core i at [i*DATA_W +: DATA_W]
- core_gnt  out  NUM_CORES  one-hot, one-cycle accept pulse
- core_valid  out  NUM_CORES  one-hot, one-cycle read-data pulse
- core_rdata  out  DATA_W  read data shared by all cores; qualified by core_valid
- mem_req  out  1  downstream request; held until mem_ack
- mem_we  out  1  downstream write enable
- mem_addr  out  ADDR_W  downstream address, 8-byte aligned
- mem_wdata  out  DATA_W  downstream write data
- mem_ack  in  1  downstream accepts the request in the cycle it is high with mem_req
- mem_rvalid  in  1  downstream read data valid
- mem_rdata  in  DATA_W  downstream read data
- busy  out  1  high whenever the FSM is not in S_IDLE
- err_misaligned  out  1  sticky; set on any accepted address with addr[2:0] != 0
- rd_count  out  32  accepted reads, wraps modulo 2^32
- wr_count  out  32  accepted writes, wraps modulo 2^32

## Operation
- The block serves one transaction at a time. There is no queueing and no outstanding-transaction overlap.
- FSM states and transitions:
  - S_IDLE: if any core_req bit is high, select a winner and go to S_GRANT.
  - S_GRANT: core_gnt[winner]=1 for exactly this cycle. At the closing edge, latch that core's addr, we and wdata. Increment rd_count or wr_count. Go to S_MEM.
  - S_MEM: drive mem_req=1 with mem_we, mem_addr and mem_wdata from the latched values. When mem_ack is high: for a write, go to S_IDLE; for a read, go to S_RDWAIT.
  - S_RDWAIT: wait for mem_rvalid. When it arrives, register mem_rdata into core_rdata, pulse core_valid[winner] for one cycle, and go to S_IDLE.
- Round-robin arbitration:
  - A pointer last_winner resets to NUM_CORES-1, so core 0 has first priority after reset.
  - The winner is the first requesting core, searching from last_winner+1 modulo NUM_CORES.
  - last_winner is updated on entry to S_GRANT.
- Alignment: mem_addr = latched addr with bits [2:0] forced to 0. A misaligned address sets err_misaligned and the access still proceeds.
- Ignored inputs:
  - mem_rvalid outside S_RDWAIT.
  - mem_ack while mem_req=0.
  - core_req from a non-winning core; it stays pending.
- core_rdata holds its last value between pulses.
- Initiators must not withdraw core_req before gnt. Behaviour after a withdrawal is undefined, but the FSM must still complete the transaction with the latched values.

## Timing
- Reset values: all outputs are 0, state is S_IDLE, last_winner is NUM_CORES-1.
- Reset asserted mid-transaction aborts it immediately: mem_req drops, and no gnt or valid is issued.
- Write path:
  - core_req is sampled high at edge E0.
  - gnt is high in cycle E0–E1.
  - mem_req is high from E1.
  - With mem_ack high on the first cycle, the block is back in S_IDLE at E2.
  - A continuously requesting core sees gnt every 3 cycles at best.
- Read path:
  - Same as the write path up to mem_ack.
  - If mem_rvalid arrives L cycles after the mem_ack edge, core_valid pulses in the cycle after mem_rvalid is sampled.
  - Minimum latency from the req edge to the valid cycle is 4 cycles.
- Outputs are registered, with no combinational path from any input to any output. core_gnt is derived from the state register.
- Simultaneous events:
  - A new core_req in the same cycle that core_valid or the write-ack return to S_IDLE is simply picked up in S_IDLE on the next edge.
  - mem_ack and mem_rvalid in the same cycle for the same read: mem_rvalid is ignored, because the FSM is not yet in S_RDWAIT. The downstream must deliver rvalid at least one cycle after ack.

## Test plan
- Single read: core 1 reads addr 0x1000; mem_ack on its first cycle and mem_rvalid 3 cycles later with 0xDEADBEEF_00000001. Required: one gnt[1] pulse, mem_addr=0x1000, mem_we=0, one valid[1] pulse with core_rdata=0xDEADBEEF_00000001, rd_count=1.
- Back-to-back writes: core 0 holds req for 4 writes to 0x2000, 0x2008, 0x2010, 0x2018 with data 1..4; mem_ack always high. Required: 4 gnt[0] pulses spaced 3 cycles apart, and mem_addr/mem_wdata sequence matching, wr_count=4.
- Round robin: after reset, cores 0, 2 and 3 request reads simultaneously. Required: grant order 0, 2, 3. If core 0 re-requests immediately, the next grant goes to 0 only after 3.
- Backpressure: mem_ack held low for 10 cycles. Required: mem_req and mem_addr stay stable, no new gnt is issued, and busy=1 throughout.
- Misaligned and stray inputs: core 2 writes to 0x3005 while a stray mem_rvalid pulses during S_MEM. Required: mem_addr=0x3000, err_misaligned=1 (sticky), no core_valid pulse.
- Reset mid-read: assert rst_n low while in S_RDWAIT. Required: all outputs are 0 asynchronously, no valid is issued, and after release a fresh read completes normally.
